// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch, load/store and unified-memory handshake signals that
// pass through the memory port arbiter. The arbiter connects via the slave
// modport; the requesters and memory model connect via the master modport.
interface mem_port_arbiter_if #(
   parameter int ADDR_W = 64,
   parameter int DATA_W = 64
);
   // fetch requester
   logic                instr_req_i;
   logic [ADDR_W-1:0]   instr_addr_i;
   logic                instr_gnt_o;
   logic                instr_rsp_valid_o;
   logic [31:0]         instr_rdata_o;

   // load/store requester
   logic                data_req_i;
   logic [ADDR_W-1:0]   data_addr_i;
   logic                data_we_i;
   logic [DATA_W-1:0]   data_wdata_i;
   logic [DATA_W/8-1:0] data_be_i;
   logic                data_gnt_o;
   logic                data_rsp_valid_o;
   logic [DATA_W-1:0]   data_rdata_o;

   // unified memory port
   logic                mem_req_o;
   logic [ADDR_W-1:0]   mem_addr_o;
   logic                mem_we_o;
   logic [DATA_W-1:0]   mem_wdata_o;
   logic [DATA_W/8-1:0] mem_be_o;
   logic                mem_gnt_i;
   logic                mem_rsp_valid_i;
   logic [DATA_W-1:0]   mem_rdata_i;

   modport slave (
      input  instr_req_i, instr_addr_i,
      input  data_req_i, data_addr_i, data_we_i, data_wdata_i, data_be_i,
      input  mem_gnt_i, mem_rsp_valid_i, mem_rdata_i,
      output instr_gnt_o, instr_rsp_valid_o, instr_rdata_o,
      output data_gnt_o, data_rsp_valid_o, data_rdata_o,
      output mem_req_o, mem_addr_o, mem_we_o, mem_wdata_o, mem_be_o
   );

   modport master (
      output instr_req_i, instr_addr_i,
      output data_req_i, data_addr_i, data_we_i, data_wdata_i, data_be_i,
      output mem_gnt_i, mem_rsp_valid_i, mem_rdata_i,
      input  instr_gnt_o, instr_rsp_valid_o, instr_rdata_o,
      input  data_gnt_o, data_rsp_valid_o, data_rdata_o,
      input  mem_req_o, mem_addr_o, mem_we_o, mem_wdata_o, mem_be_o
   );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares the single memory port between instruction fetch and load/store.
// One transaction in flight at a time; data wins ties, but fetch is forced
// through after STARVE_LIMIT consecutive data grants made while it waited.
// A request that was presented but not granted is locked so the memory
// never sees the requester switch mid-handshake.
module mem_port_arbiter #(
   parameter int ADDR_W       = 64,
   parameter int DATA_W       = 64,
   parameter int STARVE_LIMIT = 4
) (
   input  logic             clk,
   input  logic             reset,
   mem_port_arbiter_if.slave bus
);

   typedef enum logic [0:0] {
      IDLE     = 1'b0,
      WAIT_RSP = 1'b1
   } state_t;

   typedef enum logic [1:0] {
      OWN_NONE  = 2'd0,
      OWN_INSTR = 2'd1,
      OWN_DATA  = 2'd2
   } owner_t;

   localparam logic [3:0] LIMIT_C = 4'(STARVE_LIMIT);

   state_t      state_r;
   state_t      state_s;
   owner_t      owner_r;
   owner_t      lock_sel_r;
   owner_t      sel_s;
   logic        lock_r;
   logic        addr2_r;
   logic [3:0]  starve_cnt_r;
   logic        mem_req_s;
   logic        grant_s;
   logic        rsp_s;
   logic        live_s;

   // Picks the 32-bit instruction word out of the 64-bit memory beat.
   function automatic logic [31:0] pick_word(input logic [63:0] rdata, input logic upper);
      logic [31:0] word;
      if (upper) begin
         word = rdata[63:32];
      end else begin
         word = rdata[31:0];
      end
      return word;
   endfunction

   // Outputs are forced quiet for as long as reset is held.
   assign live_s = ~reset;

   // Requester selection: a locked choice sticks, otherwise starvation, then data, then fetch.
   always_comb begin
      sel_s = OWN_NONE;
      if (lock_r) begin
         sel_s = lock_sel_r;
      end else if ((starve_cnt_r == LIMIT_C) && bus.instr_req_i) begin
         sel_s = OWN_INSTR;
      end else if (bus.data_req_i) begin
         sel_s = OWN_DATA;
      end else if (bus.instr_req_i) begin
         sel_s = OWN_INSTR;
      end else begin
         sel_s = OWN_NONE;
      end
   end

   // FSM next-state and handshake decode.
   always_comb begin
      state_s   = state_r;
      mem_req_s = 1'b0;
      grant_s   = 1'b0;
      rsp_s     = 1'b0;
      case (state_r)
         IDLE: begin
            mem_req_s = (sel_s != OWN_NONE);
            grant_s   = mem_req_s && bus.mem_gnt_i;
            if (grant_s) begin
               state_s = WAIT_RSP;
            end else begin
               state_s = IDLE;
            end
         end
         WAIT_RSP: begin
            rsp_s = bus.mem_rsp_valid_i;
            if (rsp_s) begin
               state_s = IDLE;
            end else begin
               state_s = WAIT_RSP;
            end
         end
         default: begin
            state_s = IDLE;
         end
      endcase
   end

   // FSM state register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // Ownership, lock and starvation bookkeeping, updated on grant/no-grant/response.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         owner_r      <= OWN_NONE;
         lock_sel_r   <= OWN_NONE;
         lock_r       <= 1'b0;
         addr2_r      <= 1'b0;
         starve_cnt_r <= 4'd0;
      end else if (state_r == IDLE) begin
         if (grant_s) begin
            owner_r    <= sel_s;
            addr2_r    <= bus.instr_addr_i[2];
            lock_r     <= 1'b0;
            lock_sel_r <= OWN_NONE;
            if (sel_s == OWN_INSTR) begin
               starve_cnt_r <= 4'd0;
            end else if (bus.instr_req_i) begin
               if (starve_cnt_r != LIMIT_C) begin
                  starve_cnt_r <= starve_cnt_r + 4'd1;
               end else begin
                  starve_cnt_r <= starve_cnt_r;
               end
            end else begin
               starve_cnt_r <= 4'd0;
            end
         end else if (mem_req_s) begin
            lock_r     <= 1'b1;
            lock_sel_r <= sel_s;
         end else begin
            lock_r <= lock_r;
         end
      end else if (rsp_s) begin
         owner_r <= OWN_NONE;
      end else begin
         owner_r <= owner_r;
      end
   end

   // Memory-side request mux and requester-side grant/response routing.
   always_comb begin
      bus.mem_req_o         = 1'b0;
      bus.mem_addr_o        = {ADDR_W{1'b0}};
      bus.mem_we_o          = 1'b0;
      bus.mem_wdata_o       = {DATA_W{1'b0}};
      bus.mem_be_o          = {(DATA_W/8){1'b0}};
      bus.instr_gnt_o       = 1'b0;
      bus.data_gnt_o        = 1'b0;
      bus.instr_rsp_valid_o = 1'b0;
      bus.data_rsp_valid_o  = 1'b0;
      bus.instr_rdata_o     = 32'd0;
      bus.data_rdata_o      = {DATA_W{1'b0}};
      if (live_s && mem_req_s) begin
         bus.mem_req_o = 1'b1;
         if (sel_s == OWN_DATA) begin
            bus.mem_addr_o  = bus.data_addr_i;
            bus.mem_we_o    = bus.data_we_i;
            bus.mem_wdata_o = bus.data_wdata_i;
            bus.mem_be_o    = bus.data_be_i;
            bus.data_gnt_o  = grant_s;
         end else begin
            bus.mem_addr_o  = bus.instr_addr_i;
            bus.instr_gnt_o = grant_s;
         end
      end else begin
         bus.mem_req_o = 1'b0;
      end
      if (live_s && rsp_s && (owner_r == OWN_INSTR)) begin
         bus.instr_rsp_valid_o = 1'b1;
         bus.instr_rdata_o     = pick_word(bus.mem_rdata_i, addr2_r);
      end else if (live_s && rsp_s && (owner_r == OWN_DATA)) begin
         bus.data_rsp_valid_o = 1'b1;
         bus.data_rdata_o     = bus.mem_rdata_i;
      end else begin
         bus.instr_rsp_valid_o = 1'b0;
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter. Inputs change on the
// falling edge, outputs are sampled 1ns later, state advances on the rising edge.
module tb_mem_port_arbiter;

   logic clk;
   logic reset;
   int   checks;
   int   errors;

   mem_port_arbiter_if #(.ADDR_W(64), .DATA_W(64)) bus ();

   mem_port_arbiter #(.ADDR_W(64), .DATA_W(64), .STARVE_LIMIT(4)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

   task automatic drive_idle();
      bus.instr_req_i     = 1'b0;
      bus.instr_addr_i    = 64'd0;
      bus.data_req_i      = 1'b0;
      bus.data_addr_i     = 64'd0;
      bus.data_we_i       = 1'b0;
      bus.data_wdata_i    = 64'd0;
      bus.data_be_i       = 8'h00;
      bus.mem_gnt_i       = 1'b0;
      bus.mem_rsp_valid_i = 1'b0;
      bus.mem_rdata_i     = 64'd0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      drive_idle();
      bus.instr_req_i     = 1'b1;
      bus.data_req_i      = 1'b1;
      bus.mem_gnt_i       = 1'b1;
      bus.mem_rsp_valid_i = 1'b1;
      #1;
      checks++; if (bus.mem_req_o !== 1'b0) begin errors++; $display("FAIL reset_mem_req: got %0b expected 0", bus.mem_req_o); end
      checks++; if ({bus.instr_gnt_o, bus.data_gnt_o} !== 2'b00) begin errors++; $display("FAIL reset_gnt: got %0b expected 00", {bus.instr_gnt_o, bus.data_gnt_o}); end
      checks++; if ({bus.instr_rsp_valid_o, bus.data_rsp_valid_o} !== 2'b00) begin errors++; $display("FAIL reset_rsp: got %0b expected 00", {bus.instr_rsp_valid_o, bus.data_rsp_valid_o}); end
      @(negedge clk);
      drive_idle();
      @(negedge clk);
      reset = 1'b0;
      #1;
      checks++; if (bus.mem_req_o !== 1'b0) begin errors++; $display("FAIL idle_mem_req: got %0b expected 0", bus.mem_req_o); end
   endtask

   task automatic test_fetch();
      @(negedge clk);
      bus.instr_req_i  = 1'b1;
      bus.instr_addr_i = 64'h1004;
      bus.mem_gnt_i    = 1'b1;
      #1;
      checks++; if (bus.instr_gnt_o !== 1'b1) begin errors++; $display("FAIL fetch_gnt: got %0b expected 1", bus.instr_gnt_o); end
      checks++; if (bus.mem_addr_o !== 64'h1004) begin errors++; $display("FAIL fetch_addr: got %0h expected 1004", bus.mem_addr_o); end
      checks++; if ({bus.mem_we_o, bus.mem_be_o, bus.data_gnt_o} !== 10'd0) begin errors++; $display("FAIL fetch_we_be: got %0h expected 0", {bus.mem_we_o, bus.mem_be_o, bus.data_gnt_o}); end
      for (int c = 1; c <= 2; c++) begin
         @(negedge clk);
         bus.instr_req_i = 1'b0;
         bus.mem_gnt_i   = 1'b0;
         #1;
         checks++; if ({bus.mem_req_o, bus.instr_rsp_valid_o} !== 2'b00) begin errors++; $display("FAIL fetch_wait: got %0b expected 00 (cycle %0d)", {bus.mem_req_o, bus.instr_rsp_valid_o}, c); end
      end
      @(negedge clk);
      bus.mem_rsp_valid_i = 1'b1;
      bus.mem_rdata_i     = 64'hAAAA_BBBB_1111_2222;
      #1;
      checks++; if (bus.instr_rsp_valid_o !== 1'b1) begin errors++; $display("FAIL fetch_rsp: got %0b expected 1", bus.instr_rsp_valid_o); end
      checks++; if (bus.instr_rdata_o !== 32'hAAAA_BBBB) begin errors++; $display("FAIL fetch_rdata: got %0h expected aaaabbbb", bus.instr_rdata_o); end
      checks++; if ({bus.data_rsp_valid_o, bus.data_rdata_o} !== 65'd0) begin errors++; $display("FAIL fetch_no_data: got %0h expected 0", {bus.data_rsp_valid_o, bus.data_rdata_o}); end
      @(negedge clk);
      bus.mem_rsp_valid_i = 1'b0;
      #1;
      checks++; if ({bus.instr_rsp_valid_o, bus.instr_rdata_o} !== 33'd0) begin errors++; $display("FAIL fetch_rsp_pulse: got %0h expected 0", {bus.instr_rsp_valid_o, bus.instr_rdata_o}); end
   endtask

   task automatic test_simultaneous();
      @(negedge clk);
      bus.instr_req_i  = 1'b1;
      bus.instr_addr_i = 64'h1008;
      bus.data_req_i   = 1'b1;
      bus.data_addr_i  = 64'h2000;
      bus.data_we_i    = 1'b1;
      bus.data_be_i    = 8'h0F;
      bus.data_wdata_i = 64'h55;
      bus.mem_gnt_i    = 1'b1;
      #1;
      checks++; if ({bus.data_gnt_o, bus.instr_gnt_o} !== 2'b10) begin errors++; $display("FAIL sim_gnt: got %0b expected 10", {bus.data_gnt_o, bus.instr_gnt_o}); end
      checks++; if ({bus.mem_we_o, bus.mem_be_o} !== 9'h10F) begin errors++; $display("FAIL sim_we_be: got %0h expected 10f", {bus.mem_we_o, bus.mem_be_o}); end
      checks++; if ({bus.mem_addr_o, bus.mem_wdata_o} !== {64'h2000, 64'h55}) begin errors++; $display("FAIL sim_addr_wdata: got %0h/%0h expected 2000/55", bus.mem_addr_o, bus.mem_wdata_o); end
      @(negedge clk);
      bus.data_req_i      = 1'b0;
      bus.data_we_i       = 1'b0;
      bus.mem_rsp_valid_i = 1'b1;
      bus.mem_rdata_i     = 64'd0;
      #1;
      checks++; if ({bus.data_rsp_valid_o, bus.instr_rsp_valid_o, bus.mem_req_o} !== 3'b100) begin errors++; $display("FAIL sim_store_ack: got %0b expected 100", {bus.data_rsp_valid_o, bus.instr_rsp_valid_o, bus.mem_req_o}); end
      @(negedge clk);
      bus.mem_rsp_valid_i = 1'b0;
      #1;
      checks++; if ({bus.instr_gnt_o, bus.mem_addr_o, bus.mem_we_o, bus.mem_wdata_o} !== {1'b1, 64'h1008, 1'b0, 64'd0}) begin errors++; $display("FAIL sim_instr_next: got gnt=%0b addr=%0h we=%0b wdata=%0h expected 1/1008/0/0", bus.instr_gnt_o, bus.mem_addr_o, bus.mem_we_o, bus.mem_wdata_o); end
      @(negedge clk);
      bus.instr_req_i     = 1'b0;
      bus.mem_gnt_i       = 1'b0;
      bus.mem_rsp_valid_i = 1'b1;
      bus.mem_rdata_i     = 64'h1234_5678_9ABC_DEF0;
      #1;
      checks++; if ({bus.instr_rsp_valid_o, bus.instr_rdata_o} !== {1'b1, 32'h9ABC_DEF0}) begin errors++; $display("FAIL sim_instr_low: got %0b/%0h expected 1/9abcdef0", bus.instr_rsp_valid_o, bus.instr_rdata_o); end
      @(negedge clk);
      bus.mem_rsp_valid_i = 1'b0;
   endtask

   task automatic test_starvation();
      logic [9:0] order;
      order = 10'b01_1110_1111;
      bus.instr_req_i  = 1'b1;
      bus.instr_addr_i = 64'h1000;
      bus.data_req_i   = 1'b1;
      bus.data_addr_i  = 64'h4000;
      for (int i = 0; i < 10; i++) begin
         bus.mem_rsp_valid_i = 1'b0;
         bus.mem_gnt_i       = 1'b1;
         #1;
         checks++; if ({bus.data_gnt_o, bus.instr_gnt_o} !== {order[i], ~order[i]}) begin errors++; $display("FAIL starve_gnt[%0d]: got d/i=%0b expected %0b", i, {bus.data_gnt_o, bus.instr_gnt_o}, {order[i], ~order[i]}); end
         @(negedge clk);
         bus.mem_gnt_i       = 1'b0;
         bus.mem_rsp_valid_i = 1'b1;
         bus.mem_rdata_i     = {32'h0BAD_0000, 32'(i)};
         #1;
         if (order[i]) begin
            checks++; if ({bus.data_rsp_valid_o, bus.data_rdata_o} !== {1'b1, 32'h0BAD_0000, 32'(i)}) begin errors++; $display("FAIL starve_drsp[%0d]: got %0b/%0h", i, bus.data_rsp_valid_o, bus.data_rdata_o); end
         end else begin
            checks++; if ({bus.instr_rsp_valid_o, bus.instr_rdata_o} !== {1'b1, 32'(i)}) begin errors++; $display("FAIL starve_irsp[%0d]: got %0b/%0h", i, bus.instr_rsp_valid_o, bus.instr_rdata_o); end
         end
         @(negedge clk);
      end
      drive_idle();
   endtask

   task automatic test_lock();
      @(negedge clk);
      bus.instr_req_i  = 1'b1;
      bus.instr_addr_i = 64'h1010;
      for (int c = 1; c <= 3; c++) begin
         if (c == 2) begin
            bus.data_req_i  = 1'b1;
            bus.data_addr_i = 64'h5000;
         end
         #1;
         checks++; if ({bus.mem_req_o, bus.mem_addr_o, bus.instr_gnt_o, bus.data_gnt_o} !== {1'b1, 64'h1010, 2'b00}) begin errors++; $display("FAIL lock_hold[%0d]: got req=%0b addr=%0h gnt=%0b%0b expected 1/1010/00", c, bus.mem_req_o, bus.mem_addr_o, bus.instr_gnt_o, bus.data_gnt_o); end
         @(negedge clk);
      end
      bus.mem_gnt_i = 1'b1;
      #1;
      checks++; if ({bus.instr_gnt_o, bus.data_gnt_o, bus.mem_addr_o} !== {2'b10, 64'h1010}) begin errors++; $display("FAIL lock_instr_first: got %0b%0b/%0h expected 10/1010", bus.instr_gnt_o, bus.data_gnt_o, bus.mem_addr_o); end
      @(negedge clk);
      bus.instr_req_i     = 1'b0;
      bus.mem_gnt_i       = 1'b0;
      bus.mem_rsp_valid_i = 1'b1;
      bus.mem_rdata_i     = 64'hFFFF_FFFF_0000_0013;
      #1;
      checks++; if ({bus.instr_rsp_valid_o, bus.instr_rdata_o} !== {1'b1, 32'h13}) begin errors++; $display("FAIL lock_instr_rsp: got %0b/%0h expected 1/13", bus.instr_rsp_valid_o, bus.instr_rdata_o); end
      @(negedge clk);
      bus.mem_rsp_valid_i = 1'b0;
      bus.mem_gnt_i       = 1'b1;
      #1;
      checks++; if ({bus.data_gnt_o, bus.mem_addr_o} !== {1'b1, 64'h5000}) begin errors++; $display("FAIL lock_data_after: got %0b/%0h expected 1/5000", bus.data_gnt_o, bus.mem_addr_o); end
      @(negedge clk);
      bus.data_req_i      = 1'b0;
      bus.mem_gnt_i       = 1'b0;
      bus.mem_rsp_valid_i = 1'b1;
      bus.mem_rdata_i     = 64'h0123_4567_89AB_CDEF;
      #1;
      checks++; if ({bus.data_rsp_valid_o, bus.data_rdata_o} !== {1'b1, 64'h0123_4567_89AB_CDEF}) begin errors++; $display("FAIL lock_data_rsp: got %0b/%0h", bus.data_rsp_valid_o, bus.data_rdata_o); end
      @(negedge clk);
      drive_idle();
   endtask

   task automatic test_reset_in_flight();
      @(negedge clk);
      bus.data_req_i  = 1'b1;
      bus.data_addr_i = 64'h6000;
      bus.mem_gnt_i   = 1'b1;
      #1;
      checks++; if (bus.data_gnt_o !== 1'b1) begin errors++; $display("FAIL rst_pre_gnt: got %0b expected 1", bus.data_gnt_o); end
      @(negedge clk);
      bus.data_req_i   = 1'b0;
      bus.mem_gnt_i    = 1'b0;
      bus.instr_req_i  = 1'b1;
      bus.instr_addr_i = 64'h100C;
      #2;
      reset               = 1'b1;
      bus.mem_rsp_valid_i = 1'b1;
      bus.mem_rdata_i     = 64'hDEAD_BEEF_DEAD_BEEF;
      #1;
      checks++; if ({bus.mem_req_o, bus.instr_gnt_o, bus.data_gnt_o, bus.instr_rsp_valid_o, bus.data_rsp_valid_o} !== 5'd0) begin errors++; $display("FAIL rst_outputs: got %0b expected 00000", {bus.mem_req_o, bus.instr_gnt_o, bus.data_gnt_o, bus.instr_rsp_valid_o, bus.data_rsp_valid_o}); end
      checks++; if (bus.data_rdata_o !== 64'd0) begin errors++; $display("FAIL rst_rdata: got %0h expected 0", bus.data_rdata_o); end
      @(negedge clk);
      reset           = 1'b0;
      bus.instr_req_i = 1'b0;
      #1;
      checks++; if ({bus.instr_rsp_valid_o, bus.data_rsp_valid_o, bus.mem_req_o} !== 3'b000) begin errors++; $display("FAIL rst_stray_rsp: got %0b expected 000", {bus.instr_rsp_valid_o, bus.data_rsp_valid_o, bus.mem_req_o}); end
      @(negedge clk);
      bus.mem_rsp_valid_i = 1'b0;
      bus.instr_req_i     = 1'b1;
      bus.mem_gnt_i       = 1'b1;
      #1;
      checks++; if ({bus.instr_gnt_o, bus.mem_addr_o} !== {1'b1, 64'h100C}) begin errors++; $display("FAIL rst_next_gnt: got %0b/%0h expected 1/100c", bus.instr_gnt_o, bus.mem_addr_o); end
      @(negedge clk);
      bus.instr_req_i     = 1'b0;
      bus.mem_gnt_i       = 1'b0;
      bus.mem_rsp_valid_i = 1'b1;
      bus.mem_rdata_i     = 64'h1357_9BDF_2468_ACE0;
      #1;
      checks++; if ({bus.instr_rsp_valid_o, bus.instr_rdata_o} !== {1'b1, 32'h1357_9BDF}) begin errors++; $display("FAIL rst_next_rsp: got %0b/%0h expected 1/13579bdf", bus.instr_rsp_valid_o, bus.instr_rdata_o); end
      @(negedge clk);
      drive_idle();
   endtask

   task automatic test_same_cycle_rsp();
      @(negedge clk);
      bus.data_req_i      = 1'b1;
      bus.data_addr_i     = 64'h3000;
      bus.data_we_i       = 1'b0;
      bus.mem_gnt_i       = 1'b1;
      bus.mem_rsp_valid_i = 1'b1;
      bus.mem_rdata_i     = 64'hDEAD;
      #1;
      checks++; if ({bus.data_gnt_o, bus.data_rsp_valid_o, bus.mem_we_o} !== 3'b100) begin errors++; $display("FAIL early_rsp_gnt: got %0b expected 100", {bus.data_gnt_o, bus.data_rsp_valid_o, bus.mem_we_o}); end
      checks++; if (bus.data_rdata_o !== 64'd0) begin errors++; $display("FAIL early_rsp_rdata: got %0h expected 0", bus.data_rdata_o); end
      @(negedge clk);
      bus.data_req_i      = 1'b0;
      bus.mem_gnt_i       = 1'b0;
      bus.mem_rsp_valid_i = 1'b0;
      #1;
      checks++; if ({bus.data_rsp_valid_o, bus.mem_req_o} !== 2'b00) begin errors++; $display("FAIL early_rsp_wait: got %0b expected 00", {bus.data_rsp_valid_o, bus.mem_req_o}); end
      @(negedge clk);
      bus.mem_rsp_valid_i = 1'b1;
      bus.mem_rdata_i     = 64'hCAFE_F00D_0000_0042;
      #1;
      checks++; if ({bus.data_rsp_valid_o, bus.data_rdata_o} !== {1'b1, 64'hCAFE_F00D_0000_0042}) begin errors++; $display("FAIL late_rsp: got %0b/%0h", bus.data_rsp_valid_o, bus.data_rdata_o); end
      @(negedge clk);
      bus.mem_rsp_valid_i = 1'b0;
      #1;
      checks++; if ({bus.data_rsp_valid_o, bus.mem_req_o} !== 2'b00) begin errors++; $display("FAIL late_rsp_pulse: got %0b expected 00", {bus.data_rsp_valid_o, bus.mem_req_o}); end
      drive_idle();
   endtask

   initial begin
      checks = 0;
      errors = 0;
      test_reset();
      test_fetch();
      test_simultaneous();
      @(negedge clk);
      test_starvation();
      test_lock();
      test_reset_in_flight();
      test_same_cycle_rsp();
      @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Arbitrates the core's single memory port between the instruction-fetch requester and the load/store requester. Sits between the fetch/memory stages and the unified memory interface. Allows one outstanding transaction at a time and routes each response back to the requester that owns it. Data accesses have priority, with a bounded-starvation guarantee for fetch.

Parameters:
ADDR_W, 64, address width for both requesters and the memory port
DATA_W, 64, memory data width; must be 64
STARVE_LIMIT, 4, consecutive data grants allowed while fetch waits before fetch is forced to win; range 1..15

Ports:
clk  in  1  core clock
reset  in  1  asynchronous, active-high reset
instr_req_i  in  1  fetch request; held with address until instr_gnt_o
instr_addr_i  in  ADDR_W  fetch address, 4-byte aligned
instr_gnt_o  out  1  fetch request accepted this cycle
instr_rsp_valid_o  out  1  fetch response valid, one-cycle pulse
instr_rdata_o  out  32  fetched instruction
data_req_i  in  1  load/store request; held with all fields until data_gnt_o
data_addr_i  in  ADDR_W  load/store address
data_we_i  in  1  1 = store, 0 = load
data_wdata_i  in  64  store data
data_be_i  in  8  store byte enables
data_gnt_o  out  1  load/store request accepted this cycle
data_rsp_valid_o  out  1  load data valid or store ack, one-cycle pulse
data_rdata_o  out  64  load data
mem_req_o  out  1  memory request
mem_addr_o  out  ADDR_W  memory address
mem_we_o  out  1  memory write enable
mem_wdata_o  out  64  memory write data
mem_be_o  out  8  memory byte enables
mem_gnt_i  in  1  memory accepted the request this cycle
mem_rsp_valid_i  in  1  memory response valid
mem_rdata_i  in  64  memory read data

Behaviour:
- Reset (async, any state): state=IDLE, owner=NONE, lock=0, starve_cnt=0. All outputs are 0. Any in-flight response is discarded, and a mem_rsp_valid_i after reset is ignored until a new grant.
- States: IDLE and WAIT_RSP.
- IDLE, selection: if lock=0, select the requester as follows. If starve_cnt==STARVE_LIMIT and instr_req_i, select instr. Otherwise select data if data_req_i, else instr if instr_req_i. If lock=1, reuse the registered selection.
- IDLE, drive: mem_req_o=1 when a requester is selected. The mem_* fields mux combinationally from that requester. For instr: mem_we_o=0, mem_be_o=8'h00, mem_wdata_o=0.
- IDLE, no grant: if mem_req_o=1 and mem_gnt_i=0, set lock=1 and register the selection. The request must not switch requesters until granted.
- IDLE, grant: if mem_req_o=1 and mem_gnt_i=1, pulse the matching *_gnt_o combinationally in the same cycle. Register owner and the addr[2] of the instr address, clear lock, and go to WAIT_RSP.
- WAIT_RSP: mem_req_o=0 and both gnt_o=0.
  - On mem_rsp_valid_i, pulse owner's rsp_valid_o for exactly that cycle, combinationally, and return to IDLE.
  - The earliest next grant is the following cycle; throughput is at most one transaction per 2 cycles.
- mem_rsp_valid_i in IDLE is ignored.
- Response data:
  - instr_rdata_o = mem_rdata_i[63:32] when latched addr[2]=1, else mem_rdata_i[31:0].
  - data_rdata_o = mem_rdata_i.
  - Both rdata outputs are 0 when their rsp_valid_o is 0.
- starve_cnt: updated on each grant only.
  - Data grant while instr_req_i=1: increment, saturating at STARVE_LIMIT.
  - Instr grant: clear to 0.
  - Data grant while instr_req_i=0: clear to 0.
- Simultaneous requests with starve_cnt<STARVE_LIMIT: data wins. Instr stays pending and is not acknowledged.
- Requester protocol: dropping req before gnt is illegal; the design need not handle it.

Test Plan:
- Reset, then instr_req_i=1 at addr 0x1004, mem_gnt_i=1 immediately, mem_rsp_valid_i 3 cycles later with rdata 0xAAAA_BBBB_1111_2222 -> instr_gnt_o pulses in the request cycle; instr_rsp_valid_o pulses in the response cycle with instr_rdata_o=0xAAAABBBB; no data_* activity.
- Both requesters assert in the same cycle; data is a store to 0x2000 with be=0x0F and wdata=0x55; single-cycle memory -> data granted first (mem_we_o=1, mem_be_o=0x0F); data_rsp_valid_o pulses; instr granted on the next IDLE cycle.
- data_req_i held high continuously, instr_req_i held high, STARVE_LIMIT=4 -> grant order D,D,D,D,I,D,D,D,D,I; starve_cnt returns to 0 after each instr grant.
- Instr selected alone, mem_gnt_i held 0 for 3 cycles, data_req_i rises in cycle 2 -> mem_addr_o stays at the instr address and instr is granted first (lock holds); data is granted afterwards.
- Reset asserted mid-cycle while in WAIT_RSP, deasserted, then a stray mem_rsp_valid_i -> all outputs 0 immediately on reset; no rsp_valid_o pulse; the next request is arbitrated normally from IDLE.
- Load to 0x3000 with mem_rsp_valid_i asserted in the same cycle as mem_gnt_i -> the response is ignored (IDLE); data_rsp_valid_o pulses only on a later mem_rsp_valid_i in WAIT_RSP.
